// File: rtl/bus_pkg.sv
// Shared bus constants, FSM state encoding and helpers for the 1:3 bus demultiplexer.
package bus_pkg;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned STRB_W = 4;
    localparam int unsigned NSLV   = 3;

    localparam logic [DATA_W-1:0] ERR_RDATA_DEFAULT = 32'hDEAD_BEEF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        ERR  = 2'd2
    } demux_state_e;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/bus_addr_match.sv
// Combinational base/mask address decode for three slaves, lowest index wins on overlap.
module bus_addr_match
    import bus_pkg::*;
#(
    parameter logic [ADDR_W-1:0] S0_BASE = 32'h0000_0000,
    parameter logic [ADDR_W-1:0] S0_MASK = 32'hF000_0000,
    parameter logic [ADDR_W-1:0] S1_BASE = 32'h1000_0000,
    parameter logic [ADDR_W-1:0] S1_MASK = 32'hF000_0000,
    parameter logic [ADDR_W-1:0] S2_BASE = 32'h2000_0000,
    parameter logic [ADDR_W-1:0] S2_MASK = 32'hF000_0000
) (
    input  logic [ADDR_W-1:0] addr_i,
    output logic [NSLV-1:0]   hit_o,
    output logic [1:0]        idx_o
);

    always_comb begin
        hit_o[0] = ((addr_i & S0_MASK) == S0_BASE);
        hit_o[1] = ((addr_i & S1_MASK) == S1_BASE);
        hit_o[2] = ((addr_i & S2_MASK) == S2_BASE);
        idx_o    = 2'd0;
        if (hit_o[0]) begin
            idx_o = 2'd0;
        end else if (hit_o[1]) begin
            idx_o = 2'd1;
        end else if (hit_o[2]) begin
            idx_o = 2'd2;
        end
    end

endmodule

// File: rtl/bus_demux3.sv
// Routes one valid/ready master to three slaves by address, holding the route for the
// whole transaction; unmapped or silent targets complete with an error word.
module bus_demux3
    import bus_pkg::*;
#(
    parameter logic [ADDR_W-1:0] S0_BASE   = 32'h0000_0000,
    parameter logic [ADDR_W-1:0] S0_MASK   = 32'hF000_0000,
    parameter logic [ADDR_W-1:0] S1_BASE   = 32'h1000_0000,
    parameter logic [ADDR_W-1:0] S1_MASK   = 32'hF000_0000,
    parameter logic [ADDR_W-1:0] S2_BASE   = 32'h2000_0000,
    parameter logic [ADDR_W-1:0] S2_MASK   = 32'hF000_0000,
    parameter int unsigned       TIMEOUT   = 255,
    parameter logic [DATA_W-1:0] ERR_RDATA = ERR_RDATA_DEFAULT
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              m_valid,
    output logic              m_ready,
    input  logic [ADDR_W-1:0] m_addr,
    input  logic [DATA_W-1:0] m_wdata,
    input  logic [STRB_W-1:0] m_wstrb,
    output logic [DATA_W-1:0] m_rdata,
    output logic              s0_valid,
    input  logic              s0_ready,
    output logic [ADDR_W-1:0] s0_addr,
    output logic [DATA_W-1:0] s0_wdata,
    output logic [STRB_W-1:0] s0_wstrb,
    input  logic [DATA_W-1:0] s0_rdata,
    output logic              s1_valid,
    input  logic              s1_ready,
    output logic [ADDR_W-1:0] s1_addr,
    output logic [DATA_W-1:0] s1_wdata,
    output logic [STRB_W-1:0] s1_wstrb,
    input  logic [DATA_W-1:0] s1_rdata,
    output logic              s2_valid,
    input  logic              s2_ready,
    output logic [ADDR_W-1:0] s2_addr,
    output logic [DATA_W-1:0] s2_wdata,
    output logic [STRB_W-1:0] s2_wstrb,
    input  logic [DATA_W-1:0] s2_rdata,
    output logic              err,
    output logic [7:0]        err_count
);

    localparam logic [15:0] TIMEOUT_C = 16'(TIMEOUT);

    demux_state_e      state_q, state_d;
    logic [1:0]        sel_q, sel_d;
    logic [15:0]       cnt_q, cnt_d;
    logic [7:0]        err_count_q, err_count_d;

    logic [NSLV-1:0]   hit;
    logic [1:0]        hit_idx;
    logic              sel_ready;
    logic [DATA_W-1:0] sel_rdata;
    logic              fwd;
    logic              fwd_valid;

    bus_addr_match #(
        .S0_BASE(S0_BASE), .S0_MASK(S0_MASK),
        .S1_BASE(S1_BASE), .S1_MASK(S1_MASK),
        .S2_BASE(S2_BASE), .S2_MASK(S2_MASK)
    ) u_match (
        .addr_i (m_addr),
        .hit_o  (hit),
        .idx_o  (hit_idx)
    );

    always_comb begin
        case (sel_q)
            2'd0:    begin sel_ready = s0_ready; sel_rdata = s0_rdata; end
            2'd1:    begin sel_ready = s1_ready; sel_rdata = s1_rdata; end
            default: begin sel_ready = s2_ready; sel_rdata = s2_rdata; end
        endcase
    end

    always_comb begin
        state_d   = state_q;
        sel_d     = sel_q;
        cnt_d     = cnt_q;
        m_ready   = 1'b0;
        m_rdata   = '0;
        err       = 1'b0;
        fwd       = 1'b0;
        fwd_valid = 1'b0;
        case (state_q)
            IDLE: begin
                if (m_valid) begin
                    if (|hit) begin
                        sel_d   = hit_idx;
                        cnt_d   = '0;
                        state_d = BUSY;
                    end else begin
                        state_d = ERR;
                    end
                end
            end
            BUSY: begin
                fwd = 1'b1;
                // Master abort takes precedence; slave ready beats the timeout in the same cycle.
                if (!m_valid) begin
                    state_d = IDLE;
                end else if (sel_ready) begin
                    fwd_valid = 1'b1;
                    m_ready   = 1'b1;
                    m_rdata   = sel_rdata;
                    state_d   = IDLE;
                end else if (cnt_q == TIMEOUT_C) begin
                    m_ready = 1'b1;
                    m_rdata = ERR_RDATA;
                    err     = 1'b1;
                    state_d = IDLE;
                end else begin
                    fwd_valid = 1'b1;
                    cnt_d     = cnt_q + 16'd1;
                end
            end
            ERR: begin
                m_ready = 1'b1;
                m_rdata = ERR_RDATA;
                err     = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        err_count_d = err ? sat_inc8(err_count_q) : err_count_q;
    end

    always_comb begin
        s0_valid = 1'b0; s0_addr = '0; s0_wdata = '0; s0_wstrb = '0;
        s1_valid = 1'b0; s1_addr = '0; s1_wdata = '0; s1_wstrb = '0;
        s2_valid = 1'b0; s2_addr = '0; s2_wdata = '0; s2_wstrb = '0;
        if (fwd) begin
            case (sel_q)
                2'd0: begin
                    s0_valid = fwd_valid; s0_addr = m_addr; s0_wdata = m_wdata; s0_wstrb = m_wstrb;
                end
                2'd1: begin
                    s1_valid = fwd_valid; s1_addr = m_addr; s1_wdata = m_wdata; s1_wstrb = m_wstrb;
                end
                default: begin
                    s2_valid = fwd_valid; s2_addr = m_addr; s2_wdata = m_wdata; s2_wstrb = m_wstrb;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q     <= IDLE;
            sel_q       <= '0;
            cnt_q       <= '0;
            err_count_q <= '0;
        end else begin
            state_q     <= state_d;
            sel_q       <= sel_d;
            cnt_q       <= cnt_d;
            err_count_q <= err_count_d;
        end
    end

    assign err_count = err_count_q;

endmodule

// File: tb/tb_bus_demux3.sv
// Self-checking bench for bus_demux3: vector table with an expected-response queue,
// plus hand-written abort, reset and error-counter saturation sequences.
module tb_bus_demux3;

    localparam int unsigned TO = 4;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        m_valid = 1'b0, m_ready;
    logic [31:0] m_addr = '0, m_wdata = '0, m_rdata;
    logic [3:0]  m_wstrb = '0;
    logic        s0_valid, s1_valid, s2_valid;
    logic        s0_ready, s1_ready, s2_ready;
    logic [31:0] s0_addr, s1_addr, s2_addr, s0_wdata, s1_wdata, s2_wdata;
    logic [3:0]  s0_wstrb, s1_wstrb, s2_wstrb;
    logic [31:0] s0_rdata, s1_rdata, s2_rdata;
    logic        err;
    logic [7:0]  err_count;

    always #5 clk = ~clk;

    bus_demux3 #(.TIMEOUT(TO)) dut (
        .clk(clk), .resetn(resetn),
        .m_valid(m_valid), .m_ready(m_ready), .m_addr(m_addr),
        .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_rdata(m_rdata),
        .s0_valid(s0_valid), .s0_ready(s0_ready), .s0_addr(s0_addr),
        .s0_wdata(s0_wdata), .s0_wstrb(s0_wstrb), .s0_rdata(s0_rdata),
        .s1_valid(s1_valid), .s1_ready(s1_ready), .s1_addr(s1_addr),
        .s1_wdata(s1_wdata), .s1_wstrb(s1_wstrb), .s1_rdata(s1_rdata),
        .s2_valid(s2_valid), .s2_ready(s2_ready), .s2_addr(s2_addr),
        .s2_wdata(s2_wdata), .s2_wstrb(s2_wstrb), .s2_rdata(s2_rdata),
        .err(err), .err_count(err_count)
    );

    // Slave models: ready rises once valid has been held for lat[n] cycles.
    logic [15:0] lat [3];
    logic [15:0] vcnt [3];
    logic [31:0] srd [3];
    logic [2:0]  sv;
    logic [31:0] sa [3];
    logic [31:0] sw [3];
    logic [3:0]  ss [3];

    assign sv = {s2_valid, s1_valid, s0_valid};
    assign sa[0] = s0_addr;  assign sa[1] = s1_addr;  assign sa[2] = s2_addr;
    assign sw[0] = s0_wdata; assign sw[1] = s1_wdata; assign sw[2] = s2_wdata;
    assign ss[0] = s0_wstrb; assign ss[1] = s1_wstrb; assign ss[2] = s2_wstrb;
    assign s0_ready = (vcnt[0] == lat[0]);
    assign s1_ready = (vcnt[1] == lat[1]);
    assign s2_ready = (vcnt[2] == lat[2]);
    assign s0_rdata = srd[0];
    assign s1_rdata = srd[1];
    assign s2_rdata = srd[2];

    always @(posedge clk) begin
        for (int n = 0; n < 3; n++)
            vcnt[n] <= (!resetn || !sv[n] || vcnt[n] == lat[n]) ? 16'd0 : vcnt[n] + 16'd1;
    end

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic [15:0] lat;
        logic [31:0] rdata;
        int unsigned ack;
        logic [31:0] exp_rdata;
        logic        exp_err;
        int          exp_sel;   // 3 = no slave selected
    } vec_t;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int unsigned ack;
    } exp_t;

    exp_t        sbq[$];
    int          checks = 0;
    int          errors = 0;
    logic [7:0]  ecnt_model = '0;
    vec_t        tbl [10];
    vec_t        unm;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic check_all_zero(input string name);
        check(name, {m_ready, err, sv, m_rdata},
              {1'b0, 1'b0, 3'b000, 32'h0});
        check({name, "_slv"}, {sa[0] | sa[1] | sa[2], sw[0] | sw[1] | sw[2], ss[0] | ss[1] | ss[2]}, 68'h0);
    endtask

    task automatic run_vec(input vec_t v);
        exp_t       e;
        logic [2:0] exp_sv;
        bit         done;
        @(negedge clk);
        for (int n = 0; n < 3; n++) begin
            lat[n] = v.lat;
            srd[n] = (n == v.exp_sel) ? v.rdata : ~v.rdata;
        end
        m_valid = 1'b1; m_addr = v.addr; m_wdata = v.wdata; m_wstrb = v.wstrb;
        e.rdata = v.exp_rdata; e.err = v.exp_err; e.ack = v.ack;
        sbq.push_back(e);
        done = 1'b0;
        for (int k = 1; k <= 20 && !done; k++) begin
            @(posedge clk); #1;
            if (k <= int'(v.ack)) begin
                exp_sv = '0;
                if (v.exp_sel < 3 && (k < int'(v.ack) || !v.exp_err))
                    exp_sv[v.exp_sel] = 1'b1;
                check("slave_valid", sv, exp_sv);
            end
            if (k == 1) begin
                if (v.exp_sel < 3)
                    check("fwd", {sa[v.exp_sel], sw[v.exp_sel], ss[v.exp_sel]},
                          {v.addr, v.wdata, v.wstrb});
                else
                    check("fwd_none", {sa[0] | sa[1] | sa[2], ss[0] | ss[1] | ss[2]}, 36'h0);
            end
            if (m_ready) begin
                e = sbq.pop_front();
                check("ack_latency", 64'(k), 64'(e.ack));
                check("m_rdata", m_rdata, e.rdata);
                check("err", err, e.err);
                if (e.err && ecnt_model != 8'hFF) ecnt_model++;
                done = 1'b1;
            end else begin
                check("idle_out", {err, m_rdata}, 33'h0);
            end
        end
        if (!done) begin
            checks++; errors++;
            $display("FAIL ack_timeout: no m_ready within 20 cycles for addr %0h", v.addr);
            void'(sbq.pop_front());
        end
        @(posedge clk); #1;
        m_valid = 1'b0;
        check("err_count", err_count, ecnt_model);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int n = 0; n < 3; n++) begin lat[n] = 16'd0; srd[n] = '0; end
        //          addr          wdata         wstrb    lat       rdata         ack exp_rdata     err   sel
        tbl[0] = '{32'h1000_0010, 32'h0,        4'b0000, 16'd0,    32'h1234_5678, 1, 32'h1234_5678, 1'b0, 1};
        tbl[1] = '{32'h0000_0004, 32'hA5A5_0F0F, 4'b0011, 16'd3,   32'h0000_1111, 4, 32'h0000_1111, 1'b0, 0};
        tbl[2] = '{32'h8000_0000, 32'h0,        4'b0000, 16'd0,    32'h0000_0000, 1, 32'hDEAD_BEEF, 1'b1, 3};
        tbl[3] = '{32'h2000_0000, 32'h0,        4'b0000, 16'hFFFF, 32'h0000_5555, 5, 32'hDEAD_BEEF, 1'b1, 2};
        tbl[4] = '{32'h2000_0100, 32'h0,        4'b0000, 16'd4,    32'hCAFE_0002, 5, 32'hCAFE_0002, 1'b0, 2};
        tbl[5] = '{32'h1FFF_FFFC, 32'h0000_0012, 4'b1111, 16'd2,   32'h0000_2222, 3, 32'h0000_2222, 1'b0, 1};
        tbl[6] = '{32'h0FFF_FFFF, 32'h0,        4'b0000, 16'd1,    32'h7777_0000, 2, 32'h7777_0000, 1'b0, 0};
        tbl[7] = '{32'h3000_0000, 32'h1111_2222, 4'b1111, 16'd0,   32'h0000_0000, 1, 32'hDEAD_BEEF, 1'b1, 3};
        tbl[8] = '{32'hF000_0000, 32'h0,        4'b0000, 16'd0,    32'h0000_0000, 1, 32'hDEAD_BEEF, 1'b1, 3};
        tbl[9] = '{32'h0000_0000, 32'h0,        4'b0000, 16'd0,    32'hFFFF_FFFF, 1, 32'hFFFF_FFFF, 1'b0, 0};
        unm    = '{32'hC000_0040, 32'h0,        4'b0000, 16'd0,    32'h0000_0000, 1, 32'hDEAD_BEEF, 1'b1, 3};

        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset_out");
        check("reset_err_count", err_count, 8'h00);
        @(negedge clk);
        resetn = 1'b1;

        for (int i = 0; i < 10; i++)
            run_vec(tbl[i]);

        // Master abort mid-BUSY: valid to the slave drops at once, no ack, no error.
        @(negedge clk);
        for (int n = 0; n < 3; n++) lat[n] = 16'hFFFF;
        m_valid = 1'b1; m_addr = 32'h1000_0000; m_wstrb = 4'b0000;
        repeat (2) @(posedge clk);
        #1;
        check("abort_pre_valid", sv, 3'b010);
        @(negedge clk);
        m_valid = 1'b0;
        #1;
        check("abort_out", {m_ready, err, sv}, 5'b0);
        @(posedge clk); #1;
        check("abort_err_count", err_count, ecnt_model);
        run_vec(tbl[0]);

        // Reset while BUSY: transaction lost, everything back to zero, next request decodes.
        @(negedge clk);
        for (int n = 0; n < 3; n++) lat[n] = 16'hFFFF;
        m_valid = 1'b1; m_addr = 32'h2000_0000;
        repeat (2) @(posedge clk);
        #1;
        check("rst_pre_valid", sv, 3'b100);
        @(negedge clk);
        resetn = 1'b0;
        @(posedge clk); #1;
        check_all_zero("rst_busy_out");
        check("rst_err_count", err_count, 8'h00);
        ecnt_model = '0;
        @(negedge clk);
        resetn = 1'b1;
        m_valid = 1'b0;
        run_vec(tbl[1]);

        for (int i = 0; i < 258; i++)
            run_vec(unm);
        check("err_count_sat", err_count, 8'hFF);
        run_vec(tbl[4]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
